bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Sits directly upstream of seven_segment. It drives that decoder's 4-bit bcd input with one digit at a time and drives the matching active-low digit anode.
- Input digits are captured once per frame, so a mid-frame change cannot tear the displayed value.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clk cycles each digit stays selected (>= DEAD_CYCLES+1).
- DEAD_CYCLES, 2, cycles at the start of each digit slot with all anodes off (anti-ghosting).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- digits  input  4*NUM_DIGITS  packed BCD; digit k = digits[4k+3:4k]; digit 0 is rightmost.
- dp_in  input  NUM_DIGITS  decimal-point request per digit.
- bcd  output  4  BCD code of the selected digit; connects to seven_segment bcd input.
- anode  output  NUM_DIGITS  active-low digit enables; at most one bit low.
- dp  output  1  active-low decimal point for the selected digit.
- frame_start  output  1  one-cycle pulse when digit 0 begins a new frame.

Behaviour:
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..NUM_DIGITS-1), frame snapshot regs snap_digits and snap_dp.
- Reset (rst=1 at an edge):
  - cnt=0, idx=0, snap_digits=0, snap_dp=0.
  - Outputs: bcd=4'h0, anode=all 1s, dp=1, frame_start=0.
  - Reset dominates every other event, including mid-slot and mid-frame.
- Counting:
  - Each cycle out of reset, cnt increments.
  - When cnt==REFRESH_DIV-1, cnt wraps to 0 and idx advances (NUM_DIGITS-1 wraps to 0).
- Snapshot:
  - On the edge where idx wraps NUM_DIGITS-1 -> 0, snap_digits<=digits and snap_dp<=dp_in, taking the values present that cycle.
  - frame_start=1 on the cycle after that edge only.
  - The first frame after reset displays the reset snapshot (all zeros).
- Outputs:
  - All outputs are registered.
  - Each is a function of the post-edge cnt, idx and snapshot, so they are coincident with the new state. There is no combinational path from digits or dp_in to any output.
  - bcd = snap_digits[4*idx +: 4] at all times, including dead time, so the decoder has settled before the anode turns on.
  - anode = all 1s when cnt < DEAD_CYCLES; otherwise ~(1<<idx).
  - dp = 1 when cnt < DEAD_CYCLES; otherwise ~snap_dp[idx].
- Invariants:
  - Frame period = NUM_DIGITS*REFRESH_DIV cycles.
  - Each digit is lit for REFRESH_DIV-DEAD_CYCLES cycles.
  - anode is never more than one-cold.
- BCD codes 10..15 are passed through unchanged; the decoder handles them.
- Width rules:
  - cnt width = clog2(REFRESH_DIV).
  - idx width = clog2(NUM_DIGITS), minimum 1.
  - Comparisons are unsigned.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - During snapshot load, compute a blank mask. Digit k is blanked if it and every higher digit equal 0, except digit 0, which is never blanked.
  - A blanked digit keeps anode all 1s for its entire slot, and its dp is 1 unless its snap_dp bit is set. If snap_dp is set, the anode is lit with bcd=0 so the point shows.
  - The mask resets to all 0s.
- Undefined:
  - No mask logic; all digits always light, including leading zeros.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2):
- Reset, then 40 cycles with digits=16'h1234 -> first frame: bcd=0, and anode cycles 1110, 1101, 1011, 0111, each low for 6 cycles after 2 all-1s cycles. frame_start pulses at cycle 32; the next frame shows bcd 4, 3, 2, 1 for digits 0..3.
- Change digits to 16'h5678 at frame cycle 10 -> current frame still shows the 1234 values; the new value appears only after the next frame_start.
- dp_in=4'b0100 -> dp=0 only while anode=1011 and cnt>=2; otherwise dp=1.
- Assert rst for 1 cycle mid-slot (idx=2, cnt=5) -> next cycle: anode=1111, bcd=0, idx=0, cnt=0. Snapshot is cleared, and the full frame timing restarts.
- Check every cycle over 4 frames -> anode never has more than one bit low; total lit cycles per digit per frame = 6.
- With LEADING_ZERO_BLANK_EN defined, digits=16'h0070 -> digits 3 and 2 stay dark (anode 1011 and 0111 never appear), digit 1 shows 7, digit 0 shows 0. With digits=16'h0000, only digit 0 lights.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexed driver for an N-digit common-anode
// seven-segment display. It feeds one BCD digit at a time to a downstream
// seven_segment decoder and drives the matching active-low anode.
// The digit inputs are snapshotted once per frame, so the displayed value
// cannot tear when the inputs change mid-frame.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (never digit 0) are kept dark unless
//   their decimal point is requested. When undefined, every digit lights.
//
// Output timing: every output is registered and is computed from the
// post-edge counter, index and snapshot. The outputs therefore always
// agree with the internal state they describe.

module bcd_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    // Current state
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   blank_mask;

    // Next state, and the outputs derived from it
    logic [CW-1:0]           cnt_next;
    logic [IW-1:0]           idx_next;
    logic                    frame_wrap;
    logic [4*NUM_DIGITS-1:0] snap_digits_next;
    logic [NUM_DIGITS-1:0]   snap_dp_next;
    logic [NUM_DIGITS-1:0]   blank_mask_next;
    logic [3:0]              bcd_next;
    logic [NUM_DIGITS-1:0]   anode_next;
    logic                    dp_next;

    // Slot counter and digit index advance; frame_wrap marks the last slot ending
    always_comb begin
        cnt_next   = cnt + CW'(1);
        idx_next   = idx;
        frame_wrap = 1'b0;
        if (cnt == CNT_LAST) begin
            cnt_next = '0;
            if (idx == IDX_LAST) begin
                idx_next   = '0;
                frame_wrap = 1'b1;
            end else begin
                idx_next = idx + IW'(1);
            end
        end
    end

    // Frame snapshot: reload from the live inputs only at the frame boundary
    always_comb begin
        snap_digits_next = snap_digits;
        snap_dp_next     = snap_dp;
        if (frame_wrap) begin
            snap_digits_next = digits;
            snap_dp_next     = dp_in;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank mask: digit k is blanked when it and all higher digits are zero
    always_comb begin
        logic zero_above;
        blank_mask_next = blank_mask;
        zero_above      = 1'b1;
        if (frame_wrap) begin
            blank_mask_next = '0;
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                zero_above         = zero_above && (digits[4*k +: 4] == 4'h0);
                blank_mask_next[k] = zero_above;
            end
        end
    end
`else
    // No blanking: every digit always lights
    always_comb begin
        blank_mask_next = '0;
    end
`endif

    // Output decode from the post-edge index, counter and snapshot
    always_comb begin
        logic sel_dp;
        logic sel_blank;
        logic dead;
        bcd_next   = 4'h0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b0;
        anode_next = '1;
        dead       = (cnt_next < CNT_DEAD);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_next == IW'(k)) begin
                bcd_next  = snap_digits_next[4*k +: 4];
                sel_dp    = snap_dp_next[k];
                sel_blank = blank_mask_next[k];
            end
        end
        // A blanked digit still lights (showing 0) when its point is requested
        if (!dead && !(sel_blank && !sel_dp)) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                anode_next[k] = !(idx_next == IW'(k));
            end
        end
        dp_next = dead ? 1'b1 : !sel_dp;
    end

    // State and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            blank_mask  <= '0;
            bcd         <= 4'h0;
            anode       <= '1;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            idx         <= idx_next;
            snap_digits <= snap_digits_next;
            snap_dp     <= snap_dp_next;
            blank_mask  <= blank_mask_next;
            bcd         <= bcd_next;
            anode       <= anode_next;
            dp          <= dp_next;
            frame_start <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Testbench for bcd_display_scanner (NUM_DIGITS=4, REFRESH_DIV=8,
// DEAD_CYCLES=2). Expected outputs come from a cycle-count model: the
// number of edges since reset gives slot position, digit and frame.
// Builds with or without LEADING_ZERO_BLANK_EN.

module tb_bcd_display_scanner;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int DC    = 2;
    localparam int FRAME = N * RD;

    // Clock / reset block
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4*N-1:0] digits = '0;
    logic [N-1:0]   dp_in  = '0;
    logic [3:0]     bcd;
    logic [N-1:0]   anode;
    logic           dp;
    logic           frame_start;

    bcd_display_scanner #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .bcd        (bcd),
        .anode      (anode),
        .dp         (dp),
        .frame_start(frame_start)
    );

    // Expected entry: {reset_marker, bcd[3:0], anode[3:0], dp, frame_start}
    logic [10:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int          m_t     = 0;
    logic [15:0] m_snap  = '0;
    logic [3:0]  m_sdp   = '0;
    logic [3:0]  m_blank = '0;

    task automatic model_step(input logic r, input logic [15:0] d,
                              input logic [3:0] p, output logic [10:0] e);
        int   cnt;
        int   idx;
        logic fs;
        logic lit;
        logic [3:0] b;
        logic [3:0] an;
        logic dpv;
        if (r) begin
            m_t = 0; m_snap = '0; m_sdp = '0; m_blank = '0;
            e = {1'b1, 4'h0, 4'hF, 1'b1, 1'b0};
        end else begin
            m_t++;
            fs = (m_t % FRAME == 0);
            if (fs) begin
                m_snap  = d;
                m_sdp   = p;
                m_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
                for (int k = 1; k < N; k++) m_blank[k] = ((d >> (4*k)) == 16'h0);
`endif
            end
            cnt = m_t % RD;
            idx = (m_t / RD) % N;
            b   = 4'(m_snap >> (4*idx));
            lit = (cnt >= DC) && !(m_blank[idx] && !m_sdp[idx]);
            an  = lit ? ~(4'b0001 << idx) : 4'hF;
            dpv = (cnt >= DC) ? ~m_sdp[idx] : 1'b1;
            e = {1'b0, b, an, dpv, fs};
        end
    endtask

    // Driver: apply inputs, predict the post-edge outputs, queue them at the edge
    task automatic drive(input logic r, input logic [15:0] d, input logic [3:0] p);
        logic [10:0] e;
        rst = r; digits = d; dp_in = p;
        model_step(r, d, p, e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        int z;
        v = 16'($urandom_range(0, 65535));
        z = $urandom_range(0, 3);
        return v & (16'hFFFF >> (4*z));
    endfunction

    // Monitor / scoreboard: one expected entry per edge, checked mid-cycle
    logic [10:0] mon_e;
    logic [9:0]  mon_got;
    int          lit_cnt[N];
    bit          lit_valid = 1'b0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {bcd, anode, dp, frame_start};
            n_vec++;
            if (mon_got !== mon_e[9:0]) begin
                n_bad++;
                $display("FAIL outputs @%0t: got bcd=%h anode=%b dp=%b fs=%b, expected bcd=%h anode=%b dp=%b fs=%b",
                         $time, bcd, anode, dp, frame_start,
                         mon_e[9:6], mon_e[5:2], mon_e[1], mon_e[0]);
            end
            n_vec++;
            if ($countones(~anode) > 1 || $isunknown(anode)) begin
                n_bad++;
                $display("FAIL one_cold @%0t: anode=%b, expected at most one bit low", $time, anode);
            end
`ifndef LEADING_ZERO_BLANK_EN
            if (mon_e[10]) begin
                for (int k = 0; k < N; k++) lit_cnt[k] = 0;
                lit_valid = 1'b1;
            end else if (mon_e[0]) begin
                if (lit_valid) begin
                    for (int k = 0; k < N; k++) begin
                        n_vec++;
                        if (lit_cnt[k] != RD - DC) begin
                            n_bad++;
                            $display("FAIL lit_cycles digit %0d @%0t: got %0d, expected %0d",
                                     k, $time, lit_cnt[k], RD - DC);
                        end
                    end
                end
                for (int k = 0; k < N; k++) lit_cnt[k] = 0;
            end
            for (int k = 0; k < N; k++) if (anode[k] === 1'b0) lit_cnt[k]++;
`endif
        end
    end

    // Stimulus
    initial begin
        logic        r;
        logic [15:0] cur_d;
        logic [3:0]  cur_p;
        repeat (2) drive(1'b1, 16'h0000, 4'h0);
        // First frame shows the zero snapshot, then 1234
        repeat (40) drive(1'b0, 16'h1234, 4'h0);
        // Switch digits at frame cycle 10; the change waits for the next frame
        while (m_t % FRAME != 10) drive(1'b0, 16'h1234, 4'b0100);
        repeat (60) drive(1'b0, 16'h5678, 4'b0100);
        // Reset mid-slot at idx=2, cnt=5
        while (m_t % FRAME != 2*RD + 5) drive(1'b0, 16'h5678, 4'b0100);
        drive(1'b1, 16'h5678, 4'b0100);
        // Codes 10..15 pass through
        repeat (FRAME + 4) drive(1'b0, 16'h9ABC, 4'b0011);
        // Leading-zero patterns
        repeat (2*FRAME) drive(1'b0, 16'h0070, 4'h0);
        repeat (2*FRAME) drive(1'b0, 16'h0000, 4'h0);
        repeat (2*FRAME) drive(1'b0, 16'h0000, 4'b0100);
        // Randomized frames with occasional resets
        cur_d = rand_digits();
        cur_p = 4'h0;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                if ($urandom_range(0, 7) == 0) cur_d = rand_digits();
                if ($urandom_range(0, 15) == 0) cur_p = 4'($urandom_range(0, 15));
                r = ($urandom_range(0, 199) == 0);
                drive(r, cur_d, cur_p);
            end
        end
        repeat (4*FRAME) drive(1'b0, cur_d, cur_p);
        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
